// File: rtl/keccak_pkg.sv
// Shared Keccak constants, state-layout helpers, theta FSM encoding and rotl1.
package keccak_pkg;

  localparam int NUM_PLANES = 5;
  localparam int NUM_LANES  = 25;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_PARITY = 2'd1,
    ST_APPLY  = 2'd2,
    ST_DONE   = 2'd3
  } theta_fsm_t;

  // Total state width for lane width w.
  function automatic int state_width(input int w);
    return NUM_LANES * w;
  endfunction

  // Bit offset of lane (x,y) in a packed state.
  function automatic int lane_offset(input int w, input int x, input int y);
    return w * (NUM_PLANES * y + x);
  endfunction

  // Rotate the low w bits of v left by one (bit z takes bit z-1 mod w); upper bits zero.
  function automatic logic [63:0] rotl1(input logic [63:0] v, input int w);
    logic [63:0] r;
    r = '0;
    for (int i = 0; i < 64; i++) begin
      if (i < w) r[i] = v[(i == 0) ? (w - 1) : (i - 1)];
    end
    return r;
  endfunction

endpackage

// File: rtl/theta_d_gen.sv
// Combinational theta D generator: D[x] = C[x-1] ^ rotl1(C[x+1]).
module theta_d_gen
  import keccak_pkg::*;
#(
  parameter int LANE_W = 64
) (
  input  logic [NUM_PLANES*LANE_W-1:0] c,
  output logic [NUM_PLANES*LANE_W-1:0] d
);

  for (genvar gi = 0; gi < NUM_PLANES; gi++) begin : g_col
    localparam int XM = (gi + 4) % NUM_PLANES;
    localparam int XP = (gi + 1) % NUM_PLANES;
    assign d[gi*LANE_W +: LANE_W] = c[XM*LANE_W +: LANE_W]
                                  ^ LANE_W'(rotl1(64'(c[XP*LANE_W +: LANE_W]), LANE_W));
  end

endmodule

// File: rtl/theta_seq_unit.sv
// Sequential Keccak-f theta step: folds planes into column parity, then applies D in place.
// Optional feature macro: THETA_PARITY_OUT_EN exposes the column parity register as out_parity.
module theta_seq_unit
  import keccak_pkg::*;
#(
  parameter int LANE_W         = 64,
  parameter int PLANES_PER_CYC = 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [state_width(LANE_W)-1:0] in_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [state_width(LANE_W)-1:0] out_data,
`ifdef THETA_PARITY_OUT_EN
  output logic [NUM_PLANES*LANE_W-1:0]  out_parity,
`endif
  output logic                          busy
);

  localparam int         SW = state_width(LANE_W);
  localparam int         PW = NUM_PLANES * LANE_W;
  localparam logic [2:0] P3 = 3'(PLANES_PER_CYC);

  if (LANE_W != 1 && LANE_W != 2 && LANE_W != 4 && LANE_W != 8 &&
      LANE_W != 16 && LANE_W != 32 && LANE_W != 64) begin : g_bad_lane_w
    $error("theta_seq_unit: LANE_W must be 1,2,4,8,16,32 or 64");
  end
  if (PLANES_PER_CYC != 1 && PLANES_PER_CYC != 5) begin : g_bad_ppc
    $error("theta_seq_unit: PLANES_PER_CYC must be 1 or 5");
  end

  theta_fsm_t          fsm_reg, fsm_next;
  logic [2:0]          cnt_reg, cnt_next;
  logic [SW-1:0]       state_reg;
  logic [PW-1:0]       c_reg;
  logic [PW-1:0]       c_fold;
  logic [PW-1:0]       d_vec;
  logic [SW-1:0]       state_applied;
  logic [NUM_PLANES-1:0] plane_sel;
  logic [2:0]          cnt_sum;
  logic                cnt_wrap;
  logic                accept;

  assign cnt_sum  = cnt_reg + P3;
  assign cnt_wrap = (cnt_sum == 3'd5);
  assign accept   = in_valid && in_ready;

  theta_d_gen #(.LANE_W(LANE_W)) u_d_gen (
    .c (c_reg),
    .d (d_vec)
  );

  // Planes cnt..cnt+P-1 are the ones folded or updated this cycle.
  for (genvar gi = 0; gi < NUM_PLANES; gi++) begin : g_plane
    localparam int OFF = lane_offset(LANE_W, 0, gi);
    assign plane_sel[gi] = ({1'b0, cnt_reg} <= 4'(gi)) &&
                           (4'(gi) < ({1'b0, cnt_reg} + 4'(PLANES_PER_CYC)));
    assign state_applied[OFF +: PW] = plane_sel[gi] ? (state_reg[OFF +: PW] ^ d_vec)
                                                    : state_reg[OFF +: PW];
  end

  // Column parity accumulated with the selected planes.
  always_comb begin
    c_fold = c_reg;
    for (int i = 0; i < NUM_PLANES; i++) begin
      if (plane_sel[i]) c_fold = c_fold ^ state_reg[i*PW +: PW];
    end
  end

  // FSM state and plane counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_reg <= ST_IDLE;
      cnt_reg <= 3'd0;
    end else begin
      fsm_reg <= fsm_next;
      cnt_reg <= cnt_next;
    end
  end

  // Next-state, counter and handshake decode.
  always_comb begin
    fsm_next  = fsm_reg;
    cnt_next  = cnt_reg;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (fsm_reg)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          fsm_next = ST_PARITY;
          cnt_next = 3'd0;
        end
      end
      ST_PARITY: begin
        busy     = 1'b1;
        cnt_next = cnt_wrap ? 3'd0 : cnt_sum;
        if (cnt_wrap) fsm_next = ST_APPLY;
      end
      ST_APPLY: begin
        busy     = 1'b1;
        cnt_next = cnt_wrap ? 3'd0 : cnt_sum;
        if (cnt_wrap) fsm_next = ST_DONE;
      end
      ST_DONE: begin
        out_valid = 1'b1;
        if (out_ready) fsm_next = ST_IDLE;
      end
      default: fsm_next = ST_IDLE;
    endcase
  end

  // State capture, parity folding and in-place D application.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= '0;
      c_reg     <= '0;
    end else if (accept) begin
      state_reg <= in_data;
      c_reg     <= '0;
    end else if (fsm_reg == ST_PARITY) begin
      c_reg <= c_fold;
    end else if (fsm_reg == ST_APPLY) begin
      state_reg <= state_applied;
    end
  end

  assign out_data = state_reg;
`ifdef THETA_PARITY_OUT_EN
  assign out_parity = c_reg;
`endif

endmodule
